ibex_mem_responder: RTL

- Memory-side responder for the Ibex instruction/data bus protocol (req/gnt/rvalid with 7-bit integrity).
- Backs an Ibex instr or data port in OOC benches and small SoC configs.
- Provides word-addressed RAM with byte-enable writes.
- Configurable grant wait states and fixed response latency.
- Generates rdata integrity, checks wdata integrity, and flags errors.

---
 rtl/ibex_mem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ibex_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_mem_responder
//  Description : Word-addressed RAM behind an Ibex req/gnt/rvalid port, with
//                grant wait states, fixed response latency and data integrity.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int unsigned GNT_WAIT        = 0,
    parameter int unsigned RSP_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          CHECK_W_INTG    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int unsigned c_idx_w     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] c_win_bytes = 33'(MEM_WORDS) << 2;
    localparam int unsigned c_outst_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned c_wcnt_w    = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

    // Inverted Hsiao SECDED (39,32) check bits
    function automatic logic [6:0] f_enc(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606_BD25);
        p[1] = ^(d & 32'hDEBA_8050);
        p[2] = ^(d & 32'h413D_89AA);
        p[3] = ^(d & 32'h3123_4ED1);
        p[4] = ^(d & 32'hC2C1_323B);
        p[5] = ^(d & 32'h2DCC_624C);
        p[6] = ^(d & 32'h9850_5586);
        return p ^ 7'h2A;
    endfunction

    logic [31:0]          w_off;
    logic                 w_in_range;
    logic                 w_misalign;
    logic                 w_intg_bad;
    logic                 w_err;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_wait_done;
    logic                 w_slot_free;
    logic [c_outst_w-1:0] r_outst;

    logic                 w_out_valid;
    logic                 w_out_err;
    logic [31:0]          w_out_data;

    // An address below the base wraps to a huge offset and fails the window test
    assign w_off      = addr_i - ADDR_BASE;
    assign w_in_range = ({1'b0, w_off} < c_win_bytes);
    assign w_misalign = |addr_i[1:0];
    assign w_intg_bad = CHECK_W_INTG && we_i && (wdata_intg_i != f_enc(wdata_i));
    assign w_err      = !w_in_range || w_misalign || w_intg_bad;
    assign w_idx      = w_off[c_idx_w+1:2];

    generate
        if (GNT_WAIT == 0) begin : g_no_wait
            assign w_wait_done = 1'b1;
        end else begin : g_wait
            logic [c_wcnt_w-1:0] r_wcnt;

            // Saturates at GNT_WAIT so a request stalled on a full slot grants as soon as one frees
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_wcnt <= '0;
                end else if (!req_i || gnt_o) begin
                    r_wcnt <= '0;
                end else if (r_wcnt != c_wcnt_w'(GNT_WAIT)) begin
                    r_wcnt <= r_wcnt + c_wcnt_w'(1);
                end
            end

            assign w_wait_done = (r_wcnt == c_wcnt_w'(GNT_WAIT));
        end
    endgenerate

    assign w_slot_free = (r_outst < c_outst_w'(MAX_OUTSTANDING)) || rvalid_o;
    assign gnt_o       = rst_ni && req_i && w_wait_done && w_slot_free;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outst <= '0;
        end else if (gnt_o && !rvalid_o) begin
            r_outst <= r_outst + c_outst_w'(1);
        end else if (!gnt_o && rvalid_o) begin
            r_outst <= r_outst - c_outst_w'(1);
        end
    end

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_ram_q;

    always_ff @(posedge clk_i) begin
        if (gnt_o && !w_err) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                r_ram_q <= r_mem[w_idx];
            end
        end
    end

    // First response stage sits alongside the synchronous RAM output
    logic        r_s0_valid;
    logic        r_s0_err;
    logic        r_s0_rd;
    logic [31:0] w_s0_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_rd    <= 1'b0;
        end else begin
            r_s0_valid <= gnt_o;
            r_s0_err   <= gnt_o && w_err;
            r_s0_rd    <= gnt_o && !we_i && !w_err;
        end
    end

    assign w_s0_data = r_s0_rd ? r_ram_q : '0;

    generate
        if (RSP_LATENCY <= 1) begin : g_lat1
            assign w_out_valid = r_s0_valid;
            assign w_out_err   = r_s0_err;
            assign w_out_data  = w_s0_data;
        end else begin : g_latn
            logic [RSP_LATENCY-1:1] r_p_valid;
            logic [RSP_LATENCY-1:1] r_p_err;
            logic [31:0]            r_p_data [RSP_LATENCY-1:1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_p_valid <= '0;
                    r_p_err   <= '0;
                    for (int i = 1; i < RSP_LATENCY; i++) begin
                        r_p_data[i] <= '0;
                    end
                end else begin
                    r_p_valid[1] <= r_s0_valid;
                    r_p_err[1]   <= r_s0_err;
                    r_p_data[1]  <= w_s0_data;
                    for (int i = 2; i < RSP_LATENCY; i++) begin
                        r_p_valid[i] <= r_p_valid[i-1];
                        r_p_err[i]   <= r_p_err[i-1];
                        r_p_data[i]  <= r_p_data[i-1];
                    end
                end
            end

            assign w_out_valid = r_p_valid[RSP_LATENCY-1];
            assign w_out_err   = r_p_err[RSP_LATENCY-1];
            assign w_out_data  = r_p_data[RSP_LATENCY-1];
        end
    endgenerate

    assign rvalid_o     = w_out_valid;
    assign err_o        = w_out_valid && w_out_err;
    assign rdata_o      = w_out_valid ? w_out_data : '0;
    assign rdata_intg_o = f_enc(rdata_o);

endmodule
`default_nettype wire
